pipe_stall_ctrl: RTL and testbench

//  Central sequencer for the five-stage pipeline registers (PC, FD, DE, EM, MW).

---
 rtl/pipe_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: per-stage enables and clears, MD busy counter, flush deferral.
// Optional STALL_PERF_EN adds a free-running stall-cycle counter output.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D_md_req,
    input  logic              D_hz_stall,
    input  logic              E_md_start,
    input  logic              E_md_div,
    input  logic              M_wait,
    input  logic              flush_req,
    output logic              PC_en,
    output logic              FD_en,
    output logic              DE_en,
    output logic              EM_en,
    output logic              MW_en,
    output logic              FD_clear,
    output logic              DE_clear,
    output logic              EM_clear,
    output logic              MW_clear,
    output logic              md_busy,
    output logic              md_done,
    output logic              flush_pend
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [0:0] {StRun, StFlushPend} pend_state_e;

    pend_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend;
    logic             eff_flush;
    logic             d_stall;

    assign pend       = (state_q == StFlushPend);
    assign eff_flush  = (flush_req | pend) & ~M_wait;
    assign md_busy    = (cnt_q != '0);
    assign d_stall    = D_hz_stall | (D_md_req & (md_busy | E_md_start));
    assign flush_pend = pend;
    // A flush aborts the MD operation, so the final count step never reports done.
    assign md_done    = reset & (cnt_q == CntOne) & ~eff_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush arriving under a memory freeze is held until the freeze lifts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (flush_req && M_wait) begin
                    state_d = StFlushPend;
                end
            end
            StFlushPend: begin
                if (!M_wait) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (eff_flush) begin
            cnt_d = '0;
        end else if (md_busy) begin
            cnt_d = cnt_q - CntOne;
        end else if (E_md_start) begin
            cnt_d = E_md_div ? DivLoad : MultLoad;
        end
    end

    always_comb begin
        PC_en    = 1'b0;
        FD_en    = 1'b0;
        DE_en    = 1'b0;
        EM_en    = 1'b0;
        MW_en    = 1'b0;
        FD_clear = 1'b0;
        DE_clear = 1'b0;
        EM_clear = 1'b0;
        MW_clear = 1'b0;
        if (reset) begin
            if (M_wait) begin
                // Full freeze: nothing moves and no bubble is inserted.
            end else if (eff_flush) begin
                PC_en    = 1'b1;
                FD_en    = 1'b1;
                DE_en    = 1'b1;
                EM_en    = 1'b1;
                MW_en    = 1'b1;
                FD_clear = 1'b1;
                DE_clear = 1'b1;
                EM_clear = 1'b1;
            end else if (d_stall) begin
                DE_en    = 1'b1;
                EM_en    = 1'b1;
                MW_en    = 1'b1;
                DE_clear = 1'b1;
            end else begin
                PC_en = 1'b1;
                FD_en = 1'b1;
                DE_en = 1'b1;
                EM_en = 1'b1;
                MW_en = 1'b1;
            end
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (!PC_en) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a reference model pushes expected strobes per cycle,
// which are popped and compared on the falling edge.
module tb_pipe_stall_ctrl;

    localparam int MultLat = 5;
    localparam int DivLat  = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic D_md_req = 1'b0, D_hz_stall = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
    logic M_wait = 1'b0, flush_req = 1'b0;
    logic PC_en, FD_en, DE_en, EM_en, MW_en;
    logic FD_clear, DE_clear, EM_clear, MW_clear;
    logic md_busy, md_done, flush_pend;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles;
    int unsigned m_stall = 0;
`endif

    pipe_stall_ctrl #(
        .MULT_LAT(MultLat),
        .DIV_LAT (DivLat),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_md_req   (D_md_req),
        .D_hz_stall (D_hz_stall),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .M_wait     (M_wait),
        .flush_req  (flush_req),
        .PC_en      (PC_en),
        .FD_en      (FD_en),
        .DE_en      (DE_en),
        .EM_en      (EM_en),
        .MW_en      (MW_en),
        .FD_clear   (FD_clear),
        .DE_clear   (DE_clear),
        .EM_clear   (EM_clear),
        .MW_clear   (MW_clear),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .flush_pend (flush_pend)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    failures = 0;
    string cur_tag = "reset";

    // Reference model state
    int m_cnt  = 0;
    bit m_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {PC,FD,DE,EM,MW en, FD,DE,EM,MW clear, md_busy, md_done, flush_pend}
    function automatic logic [11:0] model_out(input logic r, input logic hz, input logic mreq,
                                              input logic st, input logic mw, input logic fl);
        logic [4:0] en;
        logic [3:0] clr;
        logic       busy, eff, done;
        busy = (m_cnt != 0);
        eff  = (fl || m_pend) && !mw;
        done = r && (m_cnt == 1) && !eff;
        en   = 5'b00000;
        clr  = 4'b0000;
        if (!r || mw) begin
            en  = 5'b00000;
        end else if (eff) begin
            en  = 5'b11111;
            clr = 4'b1110;
        end else if (hz || (mreq && (busy || st))) begin
            en  = 5'b00111;
            clr = 4'b0100;
        end else begin
            en  = 5'b11111;
        end
        return {en, clr, busy, done, m_pend};
    endfunction

    task automatic step(input logic r, input logic hz, input logic mreq, input logic st,
                        input logic dv, input logic mw, input logic fl);
        exp_t e;
        exp_t got_e;
        bit   eff;
        reset      = r;
        D_hz_stall = hz;
        D_md_req   = mreq;
        E_md_start = st;
        E_md_div   = dv;
        M_wait     = mw;
        flush_req  = fl;
        if (!r) begin
            m_cnt  = 0;
            m_pend = 1'b0;
`ifdef STALL_PERF_EN
            m_stall = 0;
`endif
        end
        e.v   = model_out(r, hz, mreq, st, mw, fl);
        e.tag = cur_tag;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got_e = sb_q.pop_front();
            check(got_e.tag,
                  {20'd0, PC_en, FD_en, DE_en, EM_en, MW_en, FD_clear, DE_clear, EM_clear,
                   MW_clear, md_busy, md_done, flush_pend},
                  {20'd0, got_e.v});
        end
`ifdef STALL_PERF_EN
        check({cur_tag, "_perf"}, stall_cycles, m_stall);
`endif
        @(posedge clk);
        if (r) begin
            eff = (fl || m_pend) && !mw;
`ifdef STALL_PERF_EN
            if (!e.v[11]) m_stall++;
`endif
            if (eff) m_cnt = 0;
            else if (m_cnt != 0) m_cnt--;
            else if (st) m_cnt = dv ? DivLat : MultLat;
            m_pend = mw ? (m_pend || fl) : 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held: everything zero
        @(posedge clk);
        #1;
        step(0, 1, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        cur_tag = "idle";
        idle(2);

        // T1: mult in E with mflo in D
        cur_tag = "t1_mult";
        step(1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        idle(1);

        // T2: div with unrelated D, second start mid-busy ignored
        cur_tag = "t2_div";
        step(1, 0, 0, 1, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 1, 0, 0, 0);
        idle(9);

        // T3: freeze dominates hazard stall
        cur_tag = "t3_wait";
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(1);

        // T4: flush deferred through M_wait, repeated request absorbed
        cur_tag = "t4_pend";
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // T5: flush aborts div at cnt=4; flush with start loads nothing
        cur_tag = "t5_abort";
        step(1, 0, 0, 1, 1, 0, 0);
        idle(6);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(3);
        step(1, 0, 0, 1, 1, 0, 1);
        idle(2);

        // T6: async reset mid-div with flush pending
        cur_tag = "t6_reset";
        step(1, 0, 0, 1, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Randomised traffic against the model
        cur_tag = "rand";
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        check("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
